// File: rtl/count_prog_pkg.sv
// Shared types for the programmable counter: operating modes and one-shot FSM states.
package count_prog_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } mode_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_prog_step_unit.sv
// Combinational next-count calculator: wrap or saturate at 0..MAX_VAL, with
// one spare bit of headroom so sums and differences never truncate.
module count_step_unit
    import count_prog_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  next_c,
    output logic              flow_c,
    output logic              reach_c,
    output logic              bound_c
);

    localparam int unsigned XW = WIDTH + 1;

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] stp_x;
    logic [XW-1:0] max_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] nxt_x;
    logic [XW-1:0] lim_x;
    logic          over;
    logic          under;
    logic          sat;

    // Next value, overflow/underflow flag and bound detection.
    always_comb begin
        cnt_x = XW'(count);
        stp_x = XW'(step);
        max_x = XW'(MAX_VAL);
        sum_x = cnt_x + stp_x;
        over  = (sum_x > max_x);
        under = (stp_x > cnt_x);
        sat   = (mode == 2'(SAT)) || (mode == 2'(ONESHOT));
        nxt_x = cnt_x;
        lim_x = '0;
        if (dir) begin
            lim_x  = max_x;
            flow_c = over;
            if (!over)
                nxt_x = sum_x;
            else if (sat)
                nxt_x = max_x;
            else
                nxt_x = sum_x - max_x - XW'(1);
        end else begin
            flow_c = under;
            if (!under)
                nxt_x = cnt_x - stp_x;
            else if (sat)
                nxt_x = '0;
            else
                nxt_x = cnt_x + max_x + XW'(1) - stp_x;
        end
        next_c  = WIDTH'(nxt_x);
        // Landing on the bound counts as reaching it only if the count moved.
        bound_c = (nxt_x == lim_x) && (step != '0);
        reach_c = bound_c && (nxt_x != cnt_x);
    end

endmodule

// File: rtl/count_prog.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
module count_prog
    import count_prog_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              start,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrapped,
    output logic              busy
);

    // Every step value must fit one range period, and the range must fit the register.
    if (!(((2**STEP_W) - 1 <= MAX_VAL + 1) && (MAX_VAL <= (2**WIDTH) - 1))) begin : g_bad_params
        $error("count_prog: illegal WIDTH/MAX_VAL/STEP_W combination");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    state_t           state_q;
    state_t           state_d;
    mode_t            mode_m;
    logic [WIDTH-1:0] next_c;
    logic             flow_c;
    logic             reach_c;
    logic             bound_c;
    logic [WIDTH-1:0] load_c;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             wrapped_d;
    logic             busy_d;

    assign mode_m = mode_t'(mode);
    assign load_c = (load_val > MAX_W) ? MAX_W : load_val;

    count_step_unit #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_step (
        .count   (count),
        .step    (step),
        .dir     (dir),
        .mode    (mode),
        .next_c  (next_c),
        .flow_c  (flow_c),
        .reach_c (reach_c),
        .bound_c (bound_c)
    );

    // One-shot FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // One-shot next state; load or any non-one-shot mode parks the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        if (load || (mode_m != ONESHOT)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (en && bound_c) state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        count_d   = count;
        tc_d      = 1'b0;
        wrapped_d = wrapped;
        busy_d    = (state_d == RUN);
        if (load) begin
            count_d   = load_c;
            wrapped_d = 1'b0;
        end else begin
            case (mode_m)
                SAT: begin
                    if (en) begin
                        count_d = next_c;
                        tc_d    = reach_c;
                        if (flow_c) wrapped_d = 1'b1;
                    end
                end
                ONESHOT: begin
                    if (state_q == RUN) begin
                        if (en) begin
                            count_d = next_c;
                            tc_d    = reach_c;
                            if (flow_c) wrapped_d = 1'b1;
                        end
                    end else if ((state_q == DONE) && start) begin
                        count_d = dir ? '0 : MAX_W;
                    end
                end
                default: begin
                    if (en) begin
                        count_d = next_c;
                        if (flow_c) begin
                            tc_d      = 1'b1;
                            wrapped_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            busy    <= 1'b0;
        end else begin
            count   <= count_d;
            tc      <= tc_d;
            wrapped <= wrapped_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_count_prog.sv
// Directed bench for count_prog at WIDTH=4, MAX_VAL=9, STEP_W=3.
module tb_count_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic [2:0] step;
    logic [1:0] mode;
    logic       start;
    logic [3:0] count;
    logic       tc;
    logic       wrapped;
    logic       busy;

    int errors;
    int checks;

    count_prog #(
        .WIDTH   (4),
        .MAX_VAL (9),
        .STEP_W  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .step     (step),
        .mode     (mode),
        .start    (start),
        .count    (count),
        .tc       (tc),
        .wrapped  (wrapped),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report on mismatch.
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int c, input int t, input int w, input int b);
        check({tag, ".count"},   int'(count),   c);
        check({tag, ".tc"},      int'(tc),      t);
        check({tag, ".wrapped"}, int'(wrapped), w);
        check({tag, ".busy"},    int'(busy),    b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        dir      = 1'b1;
        step     = 3'd0;
        mode     = 2'd0;
        start    = 1'b0;
        tick();
        check_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // WRAP up across the top
        load = 1'b1; load_val = 4'd8; tick();
        check_outs("wrap_up_load", 8, 0, 0, 0);
        load = 1'b0; en = 1'b1; dir = 1'b1; step = 3'd2; tick();
        check_outs("wrap_up_edge", 0, 1, 1, 0);
        en = 1'b0; tick();
        check_outs("wrap_up_hold", 0, 0, 1, 0);

        // WRAP down across zero; load clears the sticky flag
        load = 1'b1; load_val = 4'd1; tick();
        check_outs("wrap_dn_load", 1, 0, 0, 0);
        load = 1'b0; en = 1'b1; dir = 1'b0; step = 3'd3; tick();
        check_outs("wrap_dn_edge", 8, 1, 1, 0);
        tick();
        check_outs("wrap_dn_next", 5, 0, 1, 0);

        // SAT up with truncation, then holding at the bound
        en = 1'b0; mode = 2'd1;
        load = 1'b1; load_val = 4'd7; tick();
        check_outs("sat_load7", 7, 0, 0, 0);
        load = 1'b0; en = 1'b1; dir = 1'b1; step = 3'd4; tick();
        check_outs("sat_clamp", 9, 1, 1, 0);
        tick();
        check_outs("sat_hold", 9, 0, 1, 0);

        // SAT exact landing on the bound does not set wrapped
        load = 1'b1; load_val = 4'd5; tick();
        check_outs("sat_load5", 5, 0, 0, 0);
        load = 1'b0; tick();
        check_outs("sat_exact", 9, 1, 0, 0);

        // SAT down to zero with a clamp on the last step
        dir = 1'b0; tick();
        check_outs("sat_dn1", 5, 0, 0, 0);
        tick();
        check_outs("sat_dn2", 1, 0, 0, 0);
        tick();
        check_outs("sat_dn_clamp", 0, 1, 1, 0);
        tick();
        check_outs("sat_dn_hold", 0, 0, 1, 0);

        // Load beats count enable and is clamped to MAX_VAL
        load = 1'b1; load_val = 4'd12; tick();
        check_outs("load_clamp", 9, 0, 0, 0);

        // ONESHOT full run
        mode = 2'd2; load_val = 4'd0; tick();
        check_outs("os_load0", 0, 0, 0, 0);
        load = 1'b0; start = 1'b1; dir = 1'b1; step = 3'd5; en = 1'b1; tick();
        check_outs("os_start", 0, 0, 0, 1);
        start = 1'b0; tick();
        check_outs("os_run5", 5, 0, 0, 1);
        tick();
        check_outs("os_done", 9, 1, 1, 0);
        tick();
        check_outs("os_done_hold", 9, 0, 1, 0);
        start = 1'b1; tick();
        check_outs("os_restart", 0, 0, 1, 1);
        start = 1'b0; tick();
        check_outs("os_rerun5", 5, 0, 1, 1);
        en = 1'b0; start = 1'b1; tick();
        check_outs("os_start_in_run", 5, 0, 1, 1);

        // Reset mid-run aborts; a new start is needed
        start = 1'b0; en = 1'b1; rst = 1'b1; tick();
        check_outs("os_rst", 0, 0, 0, 0);
        rst = 1'b0; tick();
        check_outs("os_idle1", 0, 0, 0, 0);
        tick();
        check_outs("os_idle2", 0, 0, 0, 0);
        start = 1'b1; tick();
        check_outs("os_start2", 0, 0, 0, 1);
        start = 1'b0; tick();
        check_outs("os_run5b", 5, 0, 0, 1);

        // Leaving ONESHOT mid-run drops busy and counts as WRAP
        mode = 2'd0; tick();
        check_outs("mode_switch", 0, 1, 1, 0);

        // Step of zero holds without events
        step = 3'd0; tick();
        check_outs("step0", 0, 0, 1, 0);

        // Mode value 3 behaves as WRAP
        load = 1'b1; load_val = 4'd9; mode = 2'd3; tick();
        check_outs("mode3_load", 9, 0, 0, 0);
        load = 1'b0; step = 3'd1; dir = 1'b1; tick();
        check_outs("mode3_wrap", 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
